decode_hazard_ctrl: RTL and testbench

Hazard and bypass controller for the decode stage. Tracks destination registers of in-flight instructions in the ALU, MEM and WB stages. From these it drives the decode stall, the per-operand bypass selects for ra/rb, and a flush sequence on exceptions. It sits beside `decode_top`: it reads the fetched instruction and produces `stall_decode` plus the mux selects that pick among regfile, ALU, MEM and WB values.

---
 rtl/decode_hazard_ctrl_pkg.sv | 41 ++++
 rtl/decode_hazard_ctrl_operand_match.sv | 32 +++
 rtl/decode_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard/bypass controller.
package decode_hazard_ctrl_pkg;

  localparam int RegW = 5;

  localparam logic [6:0] OP_LD0  = 7'h10;
  localparam logic [6:0] OP_LD1  = 7'h11;
  localparam logic [6:0] OP_ST0  = 7'h12;
  localparam logic [6:0] OP_ST1  = 7'h13;
  localparam logic [6:0] OP_BEQ  = 7'h30;
  localparam logic [6:0] OP_JUMP = 7'h31;

  // R-format is any opcode with the masked bits clear; M-class covers 0x10..0x13
  localparam logic [6:0] OP_R_MASK = 7'h70;
  localparam logic [6:0] OP_M_MASK = 7'h7C;
  localparam logic [6:0] OP_M_BASE = 7'h10;

  typedef enum logic [1:0] {
    BP_RF  = 2'd0,
    BP_ALU = 2'd1,
    BP_MEM = 2'd2,
    BP_WB  = 2'd3
  } bypass_sel_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic            valid;
    logic [RegW-1:0] rd;
    logic            isLoad;
  } slot_t;

  function automatic logic slotHit(input slot_t s, input logic [RegW-1:0] src);
    return s.valid && (s.rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/decode_hazard_ctrl_operand_match.sv
// Per-operand bypass select: youngest matching slot wins, a load in ALU is a hazard.
module hazard_operand_match
  import decode_hazard_ctrl_pkg::*;
(
  input  logic [RegW-1:0] src_i,
  input  logic            use_i,
  input  slot_t           slotAlu_i,
  input  slot_t           slotMem_i,
  input  slot_t           slotWb_i,
  output bypass_sel_e     sel_o,
  output logic            loadUse_o
);

  logic unusedFlags;
  assign unusedFlags = slotMem_i.isLoad ^ slotWb_i.isLoad;

  always_comb begin
    sel_o     = BP_RF;
    loadUse_o = 1'b0;
    if (use_i) begin
      if (slotHit(slotAlu_i, src_i)) begin
        if (slotAlu_i.isLoad) loadUse_o = 1'b1;
        else                  sel_o     = BP_ALU;
      end else if (slotHit(slotMem_i, src_i)) begin
        sel_o = BP_MEM;
      end else if (slotHit(slotWb_i, src_i)) begin
        sel_o = BP_WB;
      end
    end
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: tracks ALU/MEM/WB destinations, drives stall and bypass selects.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_CNT_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset_c,
  input  logic                  fetch_instr_valid,
  input  logic [31:0]           fetch_instr_data,
  input  logic                  pipe_stall,
  input  logic                  excV,
  output logic                  stall_decode,
  output logic                  issue_valid,
  output logic [1:0]            bypass_sel_a,
  output logic [1:0]            bypass_sel_b,
  output logic [REG_ADDR_W-1:0] rd_alu,
  output logic [REG_ADDR_W-1:0] rd_mem,
  output logic [REG_ADDR_W-1:0] rd_wb,
  output logic [PERF_CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

  logic [6:0]      opcode;
  logic [RegW-1:0] rdF, raF, rbF, srcB;
  logic            isR, isLd, isSt, isBeq;
  logic            useA, useB, writesRd;
  logic            unusedLowBits;

  assign opcode        = fetch_instr_data[31:25];
  assign rdF           = fetch_instr_data[24:20];
  assign raF           = fetch_instr_data[19:15];
  assign rbF           = fetch_instr_data[14:10];
  assign unusedLowBits = ^fetch_instr_data[9:0];

  assign isR   = (opcode & OP_R_MASK) == 7'h00;
  assign isLd  = (opcode == OP_LD0) || (opcode == OP_LD1);
  assign isSt  = (opcode == OP_ST0) || (opcode == OP_ST1);
  assign isBeq = (opcode == OP_BEQ);

  // Stores forward their data register (rd field) through the second operand path
  assign useA     = isR | isLd | isSt | isBeq;
  assign useB     = isR | isBeq | isSt;
  assign srcB     = isSt ? rdF : rbF;
  assign writesRd = (isR | isLd) && (rdF != '0);

  slot_t       slotAlu_q, slotMem_q, slotWb_q;
  slot_t       slotAlu_d, slotMem_d, slotWb_d;
  hz_state_e   state_q;
  logic [2:0]  flushCnt_q;
  logic [PERF_CNT_W-1:0] stallCnt_q;

  bypass_sel_e selA, selB;
  logic        luA, luB, loadUse;

  hazard_operand_match uMatchA (
    .src_i     (raF),
    .use_i     (useA),
    .slotAlu_i (slotAlu_q),
    .slotMem_i (slotMem_q),
    .slotWb_i  (slotWb_q),
    .sel_o     (selA),
    .loadUse_o (luA)
  );

  hazard_operand_match uMatchB (
    .src_i     (srcB),
    .use_i     (useB),
    .slotAlu_i (slotAlu_q),
    .slotMem_i (slotMem_q),
    .slotWb_i  (slotWb_q),
    .sel_o     (selB),
    .loadUse_o (luB)
  );

  assign loadUse      = fetch_instr_valid & (luA | luB);
  assign stall_decode = pipe_stall | loadUse | (state_q == ST_FLUSH) | excV;
  assign issue_valid  = fetch_instr_valid & ~stall_decode;
  assign bypass_sel_a = selA;
  assign bypass_sel_b = selB;

  assign rd_alu    = REG_ADDR_W'(slotAlu_q.valid ? slotAlu_q.rd : '0);
  assign rd_mem    = REG_ADDR_W'(slotMem_q.valid ? slotMem_q.rd : '0);
  assign rd_wb     = REG_ADDR_W'(slotWb_q.valid  ? slotWb_q.rd  : '0);
  assign stall_cnt = stallCnt_q;

  always_comb begin
    slotAlu_d = slotAlu_q;
    slotMem_d = slotMem_q;
    slotWb_d  = slotWb_q;
    if (excV) begin
      slotAlu_d = '0;
      slotMem_d = '0;
      slotWb_d  = '0;
    end else if (!pipe_stall) begin
      slotWb_d         = slotMem_q;
      slotMem_d        = slotAlu_q;
      slotAlu_d.valid  = issue_valid & writesRd;
      slotAlu_d.rd     = rdF;
      slotAlu_d.isLoad = isLd;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_c) begin
      slotAlu_q <= '0;
      slotMem_q <= '0;
      slotWb_q  <= '0;
    end else begin
      slotAlu_q <= slotAlu_d;
      slotMem_q <= slotMem_d;
      slotWb_q  <= slotWb_d;
    end
  end

  // Exception handling overrides every other transition, including a frozen pipe
  always_ff @(posedge clock) begin
    if (reset_c) begin
      state_q    <= ST_RUN;
      flushCnt_q <= 3'd0;
    end else if (excV) begin
      state_q    <= ST_FLUSH;
      flushCnt_q <= FlushLoad;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!pipe_stall && loadUse) state_q <= ST_LOAD_STALL;
        end
        ST_LOAD_STALL: begin
          if (!pipe_stall) state_q <= ST_RUN;
        end
        ST_FLUSH: begin
          if (flushCnt_q <= 3'd1) begin
            state_q    <= ST_RUN;
            flushCnt_q <= 3'd0;
          end else begin
            flushCnt_q <= flushCnt_q - 3'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_c)                              stallCnt_q <= '0;
    else if (stall_decode && stallCnt_q != '1) stallCnt_q <= stallCnt_q + 1'b1;
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed-vector scoreboard bench for decode_hazard_ctrl (FLUSH_CYCLES=2, 8-bit perf counter).
module tb_decode_hazard_ctrl;

  localparam logic [6:0] OpAdd = 7'h01;
  localparam logic [6:0] OpLd  = 7'h10;
  localparam logic [6:0] OpSt  = 7'h12;

  logic        clock;
  logic        reset_c;
  logic        fetch_instr_valid;
  logic [31:0] fetch_instr_data;
  logic        pipe_stall;
  logic        excV;
  logic        stall_decode;
  logic        issue_valid;
  logic [1:0]  bypass_sel_a;
  logic [1:0]  bypass_sel_b;
  logic [4:0]  rd_alu, rd_mem, rd_wb;
  logic [7:0]  stall_cnt;

  typedef struct {
    logic       stall;
    logic       issue;
    logic [1:0] selA;
    logic [1:0] selB;
    logic [4:0] rdAlu;
    logic [4:0] rdMem;
    logic [4:0] rdWb;
    logic [7:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   vectorsApplied = 0;
  int   miscompares    = 0;

  decode_hazard_ctrl #(
    .REG_ADDR_W   (5),
    .FLUSH_CYCLES (2),
    .PERF_CNT_W   (8)
  ) dut (
    .clock             (clock),
    .reset_c           (reset_c),
    .fetch_instr_valid (fetch_instr_valid),
    .fetch_instr_data  (fetch_instr_data),
    .pipe_stall        (pipe_stall),
    .excV              (excV),
    .stall_decode      (stall_decode),
    .issue_valid       (issue_valid),
    .bypass_sel_a      (bypass_sel_a),
    .bypass_sel_b      (bypass_sel_b),
    .rd_alu            (rd_alu),
    .rd_mem            (rd_mem),
    .rd_wb             (rd_wb),
    .stall_cnt         (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb);
    return {op, rd, ra, rb, 10'd0};
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic ps,
                               input logic ex, input logic eStall, input logic eIssue,
                               input logic [1:0] eA, input logic [1:0] eB,
                               input logic [4:0] eAlu, input logic [4:0] eMem,
                               input logic [4:0] eWb, input logic [7:0] eCnt);
    exp_t e;
    @(posedge clock);
    #1;
    fetch_instr_valid = v;
    fetch_instr_data  = ins;
    pipe_stall        = ps;
    excV              = ex;
    e.stall = eStall; e.issue = eIssue; e.selA = eA; e.selB = eB;
    e.rdAlu = eAlu;   e.rdMem = eMem;   e.rdWb = eWb; e.cnt = eCnt;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    vectorsApplied++;
    if (stall_decode !== e.stall) begin
      miscompares++;
      $display("[TB] FAIL vec%0d stall_decode got %b want %b", vectorsApplied, stall_decode, e.stall);
    end
    if (issue_valid !== e.issue) begin
      miscompares++;
      $display("[TB] FAIL vec%0d issue_valid got %b want %b", vectorsApplied, issue_valid, e.issue);
    end
    // Selects are meaningless while decode is stalled
    if (!e.stall && bypass_sel_a !== e.selA) begin
      miscompares++;
      $display("[TB] FAIL vec%0d bypass_sel_a got %0d want %0d", vectorsApplied, bypass_sel_a, e.selA);
    end
    if (!e.stall && bypass_sel_b !== e.selB) begin
      miscompares++;
      $display("[TB] FAIL vec%0d bypass_sel_b got %0d want %0d", vectorsApplied, bypass_sel_b, e.selB);
    end
    if (rd_alu !== e.rdAlu || rd_mem !== e.rdMem || rd_wb !== e.rdWb) begin
      miscompares++;
      $display("[TB] FAIL vec%0d slots got %0d/%0d/%0d want %0d/%0d/%0d", vectorsApplied,
               rd_alu, rd_mem, rd_wb, e.rdAlu, e.rdMem, e.rdWb);
    end
    if (stall_cnt !== e.cnt) begin
      miscompares++;
      $display("[TB] FAIL vec%0d stall_cnt got %0d want %0d", vectorsApplied, stall_cnt, e.cnt);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int cntExp;
    reset_c = 1'b1;
    fetch_instr_valid = 1'b0;
    fetch_instr_data  = 32'd0;
    pipe_stall = 1'b0;
    excV       = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_c = 1'b0;

    // Reset state
    applyStimulus(0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ALU-to-ALU forwarding
    applyStimulus(1, mk(OpAdd, 3, 1, 2), 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, mk(OpAdd, 4, 3, 3), 0, 0, 0, 1, 1, 1, 3, 0, 0, 0);
    // Load-use: one bubble, then MEM forwarding
    applyStimulus(1, mk(OpLd, 5, 1, 0), 0, 0, 0, 1, 0, 0, 4, 3, 0, 0);
    applyStimulus(1, mk(OpAdd, 6, 5, 1), 0, 0, 1, 0, 0, 0, 5, 4, 3, 0);
    applyStimulus(1, mk(OpAdd, 6, 5, 1), 0, 0, 0, 1, 2, 0, 0, 5, 4, 1);
    // WB forwarding to store data, then out of range
    applyStimulus(1, mk(OpAdd, 7, 1, 2), 0, 0, 0, 1, 0, 0, 6, 0, 5, 1);
    applyStimulus(1, mk(OpAdd, 8, 1, 2), 0, 0, 0, 1, 0, 0, 7, 6, 0, 1);
    applyStimulus(1, mk(OpAdd, 9, 1, 2), 0, 0, 0, 1, 0, 0, 8, 7, 6, 1);
    applyStimulus(1, mk(OpSt, 7, 1, 0), 0, 0, 0, 1, 0, 3, 9, 8, 7, 1);
    applyStimulus(1, mk(OpAdd, 10, 7, 7), 0, 0, 0, 1, 0, 0, 0, 9, 8, 1);
    // r0 is never tracked and never matched
    applyStimulus(1, mk(OpAdd, 0, 1, 2), 0, 0, 0, 1, 0, 0, 10, 0, 9, 1);
    applyStimulus(1, mk(OpAdd, 11, 0, 0), 0, 0, 0, 1, 0, 0, 0, 10, 0, 1);
    applyStimulus(1, mk(OpLd, 0, 1, 0), 0, 0, 0, 1, 0, 0, 11, 0, 10, 1);
    applyStimulus(1, mk(OpAdd, 12, 0, 0), 0, 0, 0, 1, 0, 0, 0, 11, 0, 1);
    // Exception with all three slots full
    applyStimulus(1, mk(OpAdd, 13, 1, 2), 0, 0, 0, 1, 0, 0, 12, 0, 11, 1);
    applyStimulus(1, mk(OpAdd, 14, 1, 2), 0, 0, 0, 1, 0, 0, 13, 12, 0, 1);
    applyStimulus(1, mk(OpAdd, 15, 14, 1), 0, 1, 1, 0, 0, 0, 14, 13, 12, 1);
    applyStimulus(1, mk(OpAdd, 15, 14, 1), 0, 0, 1, 0, 0, 0, 0, 0, 0, 2);
    applyStimulus(1, mk(OpAdd, 15, 14, 1), 0, 0, 1, 0, 0, 0, 0, 0, 0, 3);
    applyStimulus(1, mk(OpAdd, 15, 14, 1), 0, 0, 0, 1, 0, 0, 0, 0, 0, 4);
    // pipe_stall held during LOAD_STALL
    applyStimulus(1, mk(OpLd, 16, 1, 0), 0, 0, 0, 1, 0, 0, 15, 0, 0, 4);
    applyStimulus(1, mk(OpAdd, 17, 16, 2), 0, 0, 1, 0, 0, 0, 16, 15, 0, 4);
    applyStimulus(1, mk(OpAdd, 17, 16, 2), 1, 0, 1, 0, 0, 0, 0, 16, 15, 5);
    applyStimulus(1, mk(OpAdd, 17, 16, 2), 1, 0, 1, 0, 0, 0, 0, 16, 15, 6);
    applyStimulus(1, mk(OpAdd, 17, 16, 2), 1, 0, 1, 0, 0, 0, 0, 16, 15, 7);
    applyStimulus(1, mk(OpAdd, 17, 16, 2), 0, 0, 0, 1, 2, 0, 0, 16, 15, 8);
    // Counter saturation: 2^8+5 stall cycles
    for (int i = 0; i < 261; i++) begin
      cntExp = (8 + i > 255) ? 255 : 8 + i;
      applyStimulus(0, 32'd0, 1, 0, 1, 0, 0, 0, 17, 0, 16, cntExp[7:0]);
    end
    applyStimulus(0, 32'd0, 0, 0, 0, 0, 0, 0, 17, 0, 16, 8'd255);

    @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected vectors left unchecked, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
